// File: rtl/key_debounce_multi.sv
// rtl/key_debounce_multi.sv - N-channel key synchroniser/debouncer with press/release/long-press events and pending interrupt
module key_debounce_multi #(
    parameter int KEY_NUM    = 4,
    parameter int CNT_MAX    = 999_999,
    parameter int LONG_MAX   = 49_999_999,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [KEY_NUM-1:0] key_in,
    input  logic [KEY_NUM-1:0] irq_en,
    input  logic [KEY_NUM-1:0] irq_ack,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] press_flag,
    output logic [KEY_NUM-1:0] release_flag,
    output logic [KEY_NUM-1:0] long_flag,
    output logic [KEY_NUM-1:0] pending,
    output logic               irq
);
    localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam int HW = (LONG_MAX > 0) ? $clog2(LONG_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_TOP  = CW'(CNT_MAX);
    localparam logic [HW-1:0] HOLD_TOP = HW'(LONG_MAX);
    localparam logic [KEY_NUM-1:0] IDLE_LVL = ACTIVE_LOW ? {KEY_NUM{1'b1}} : {KEY_NUM{1'b0}};

    logic [KEY_NUM-1:0] s1;
    logic [KEY_NUM-1:0] s2;
    logic [KEY_NUM-1:0] raw;

    // Synchronisers reset to the idle pin level so leaving reset never looks like a press.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s1 <= IDLE_LVL;
            s2 <= IDLE_LVL;
        end else begin
            s1 <= key_in;
            s2 <= s1;
        end
    end

    assign raw = ACTIVE_LOW ? ~s2 : s2;

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        logic [CW-1:0] cnt;
        logic [HW-1:0] hold;
        logic          state_q;
        logic          press_q;
        logic          release_q;
        logic          long_q;

        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                cnt       <= '0;
                state_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                if (raw[i] == state_q) begin
                    cnt <= '0;
                end else if (cnt == CNT_TOP) begin
                    cnt       <= '0;
                    state_q   <= raw[i];
                    press_q   <= raw[i];
                    release_q <= ~raw[i];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        // Hold counter saturates at HOLD_TOP, so long_q can fire only once per press.
        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                hold   <= '0;
                long_q <= 1'b0;
            end else begin
                long_q <= 1'b0;
                if (!state_q) begin
                    hold <= '0;
                end else if (hold < HOLD_TOP) begin
                    hold   <= hold + 1'b1;
                    long_q <= (hold == HOLD_TOP - 1'b1);
                end
            end
        end

        assign key_state[i]    = state_q;
        assign press_flag[i]   = press_q;
        assign release_flag[i] = release_q;
        assign long_flag[i]    = long_q;
    end

    // New events take priority over a simultaneous acknowledge.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pending <= '0;
            irq     <= 1'b0;
        end else begin
            pending <= (pending & ~irq_ack) | press_flag | long_flag;
            irq     <= |(pending & irq_en);
        end
    end
endmodule

// File: tb/tb_key_debounce_multi.sv
// tb/tb_key_debounce_multi.sv - directed self-checking bench for key_debounce_multi
module tb_key_debounce_multi;
    logic       clk;
    logic       rst;
    logic [3:0] key_in;
    logic [3:0] irq_en;
    logic [3:0] irq_ack;
    logic [3:0] key_state;
    logic [3:0] press_flag;
    logic [3:0] release_flag;
    logic [3:0] long_flag;
    logic [3:0] pending;
    logic       irq;

    int checks;
    int errors;

    key_debounce_multi #(
        .KEY_NUM(4),
        .CNT_MAX(3),
        .LONG_MAX(20),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .key_in(key_in),
        .irq_en(irq_en),
        .irq_ack(irq_ack),
        .key_state(key_state),
        .press_flag(press_flag),
        .release_flag(release_flag),
        .long_flag(long_flag),
        .pending(pending),
        .irq(irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; key_in = 4'hF; irq_en = 4'h0; irq_ack = 4'h0;
        step(3);
        checks++;
        if ({key_state, press_flag, release_flag, long_flag, pending, irq} !== 21'd0) begin
            errors++;
            $display("FAIL reset_in_reset: got ks=%h pf=%h rf=%h lf=%h pend=%h irq=%b, want all 0",
                     key_state, press_flag, release_flag, long_flag, pending, irq);
        end
        rst = 1'b0;
        step(20);
        checks++;
        if ({key_state, press_flag, release_flag, long_flag, pending, irq} !== 21'd0) begin
            errors++;
            $display("FAIL reset_idle: got ks=%h pf=%h rf=%h lf=%h pend=%h irq=%b, want all 0",
                     key_state, press_flag, release_flag, long_flag, pending, irq);
        end
    endtask

    task automatic test_press();
        irq_en = 4'h1;
        key_in[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            checks++;
            if (press_flag[0] !== (k == 6)) begin
                errors++;
                $display("FAIL press0_flag edge %0d: got %b want %b", k, press_flag[0], k == 6);
            end
            checks++;
            if (key_state[0] !== (k >= 6)) begin
                errors++;
                $display("FAIL press0_state edge %0d: got %b want %b", k, key_state[0], k >= 6);
            end
            checks++;
            if (pending[0] !== (k >= 7)) begin
                errors++;
                $display("FAIL press0_pending edge %0d: got %b want %b", k, pending[0], k >= 7);
            end
            checks++;
            if (irq !== (k >= 8)) begin
                errors++;
                $display("FAIL press0_irq edge %0d: got %b want %b", k, irq, k >= 8);
            end
        end
        key_in[0] = 1'b1;
        step(10);
        checks++;
        if (key_state[0] !== 1'b0) begin
            errors++;
            $display("FAIL press0_release_state: got %b want 0", key_state[0]);
        end
    endtask

    task automatic test_bounce();
        int seen;
        seen = 0;
        for (int r = 0; r < 10; r++) begin
            key_in[1] = 1'b0;
            for (int k = 0; k < 3; k++) begin
                step(1);
                if (press_flag[1] || key_state[1]) seen++;
            end
            key_in[1] = 1'b1;
            step(1);
            if (press_flag[1] || key_state[1]) seen++;
        end
        for (int k = 0; k < 10; k++) begin
            step(1);
            if (press_flag[1] || key_state[1]) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL bounce_no_press: got %0d cycles with press/state, want 0", seen);
        end
        checks++;
        if (pending[1] !== 1'b0) begin
            errors++;
            $display("FAIL bounce_pending: got %b want 0", pending[1]);
        end
    endtask

    task automatic test_long_press();
        int pc, pcyc, lc, lcyc, rc, rcyc, lc2;
        pc = 0; pcyc = -1; lc = 0; lcyc = -1; rc = 0; rcyc = -1; lc2 = 0;
        key_in[2] = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            if (press_flag[2]) begin pc++; pcyc = k; end
            if (long_flag[2]) begin lc++; lcyc = k; end
        end
        key_in[2] = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step(1);
            if (release_flag[2]) begin rc++; rcyc = k; end
            if (long_flag[2] || press_flag[2]) lc2++;
        end
        checks++;
        if (pc !== 1 || pcyc !== 6) begin
            errors++;
            $display("FAIL long_press_flag: got count=%0d edge=%0d want count=1 edge=6", pc, pcyc);
        end
        checks++;
        if (lc !== 1 || lcyc !== 26) begin
            errors++;
            $display("FAIL long_flag: got count=%0d edge=%0d want count=1 edge=26", lc, lcyc);
        end
        checks++;
        if (rc !== 1 || rcyc !== 6) begin
            errors++;
            $display("FAIL long_release_flag: got count=%0d edge=%0d want count=1 edge=6", rc, rcyc);
        end
        checks++;
        if (lc2 !== 0) begin
            errors++;
            $display("FAIL long_after_release: got %0d extra events want 0", lc2);
        end
        checks++;
        if (pending[2] !== 1'b1 || key_state[2] !== 1'b0) begin
            errors++;
            $display("FAIL long_pending_state: got pend=%b ks=%b want pend=1 ks=0", pending[2], key_state[2]);
        end
    endtask

    task automatic test_ack();
        key_in[0] = 1'b0;
        step(6);
        checks++;
        if (press_flag[0] !== 1'b1 || pending[0] !== 1'b1) begin
            errors++;
            $display("FAIL ack_setup: got pf=%b pend=%b want pf=1 pend=1", press_flag[0], pending[0]);
        end
        irq_ack = 4'h1;
        step(1);
        irq_ack = 4'h0;
        checks++;
        if (pending[0] !== 1'b1) begin
            errors++;
            $display("FAIL ack_set_wins: got %b want 1", pending[0]);
        end
        key_in[0] = 1'b1;
        step(2);
        irq_ack = 4'h1;
        step(1);
        irq_ack = 4'h0;
        checks++;
        if (pending[0] !== 1'b0 || pending[2] !== 1'b1) begin
            errors++;
            $display("FAIL ack_clear: got pend=%h want bit0=0 bit2=1", pending);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL ack_irq_lag: got %b want 1", irq);
        end
        step(1);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL ack_irq_drop: got %b want 0", irq);
        end
        step(10);
        checks++;
        if (pending[0] !== 1'b0 || key_state[0] !== 1'b0) begin
            errors++;
            $display("FAIL ack_settled: got pend0=%b ks0=%b want 0 0", pending[0], key_state[0]);
        end
    endtask

    task automatic test_reset_mid_debounce();
        int bad;
        bad = 0;
        key_in[3] = 1'b0;
        step(2);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1);
            if (press_flag !== 4'h0 || release_flag !== 4'h0 || long_flag !== 4'h0 || key_state !== 4'h0)
                bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL rst_no_flags: got %0d cycles with activity want 0", bad);
        end
        checks++;
        if (pending !== 4'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL rst_pending: got pend=%h irq=%b want 0 0", pending, irq);
        end
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            checks++;
            if (press_flag[3] !== (k == 6)) begin
                errors++;
                $display("FAIL rst_press3 edge %0d: got %b want %b", k, press_flag[3], k == 6);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_press();
        test_bounce();
        test_long_press();
        test_ack();
        test_reset_mid_debounce();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
- Parametrised N-channel push-button conditioner for the 8088 system board.
- Each channel is synchronised and debounced. The block emits one-cycle press, release and long-press pulses per key.
- Events are latched into a pending register that drives a level interrupt toward the interrupt controller.
- Software clears pending bits through a per-channel acknowledge.

Parameters:
- KEY_NUM, 4, number of independent key channels.
- CNT_MAX, 999_999, debounce compare value; a new level must persist CNT_MAX+1 cycles (20 ms at 50 MHz).
- LONG_MAX, 49_999_999, hold cycles after the debounced press before long_flag fires (1 s at 50 MHz).
- ACTIVE_LOW, 1, 1 = key_in low means pressed; 0 = high means pressed.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst  in  1  synchronous reset, active-high.
- key_in  in  KEY_NUM  raw asynchronous key pins.
- irq_en  in  KEY_NUM  per-channel interrupt enable.
- irq_ack  in  KEY_NUM  one-cycle clear strobe for the pending bits.
- key_state  out  KEY_NUM  debounced level, 1 = pressed.
- press_flag  out  KEY_NUM  1-cycle pulse on debounced press.
- release_flag  out  KEY_NUM  1-cycle pulse on debounced release.
- long_flag  out  KEY_NUM  1-cycle pulse once per hold reaching LONG_MAX.
- pending  out  KEY_NUM  latched event bits.
- irq  out  1  registered OR of (pending & irq_en).

Behaviour:
- Reset (sync, sys_rst=1 at a sys_clk edge):
  - Synchronisers load "released" level: 1 if ACTIVE_LOW, else 0.
  - Debounce and hold counters go to 0.
  - key_state, all flags, pending and irq go to 0.
  - Reset mid-debounce or mid-hold discards progress; no pulse is emitted in the reset cycle.
- Input conditioning, per channel:
  - Two-flop synchroniser s1 -> s2.
  - raw = ACTIVE_LOW ? ~s2 : s2.
- Debounce counter, per channel; width $clog2(CNT_MAX+1):
  - raw == key_state: cnt <= 0.
  - Else if cnt == CNT_MAX: key_state <= raw and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any bounce back to key_state restarts the count from 0.
- Latency: key_state toggles at the (CNT_MAX+3)th edge after the first edge sampling a steady new pin level.
- press_flag / release_flag:
  - Registered pulses asserted in the same cycle key_state becomes 1 / 0 respectively.
  - Exactly one cycle high.
- Hold counter, per channel; width $clog2(LONG_MAX+1):
  - key_state=0: hold <= 0.
  - key_state=1 and hold < LONG_MAX: hold <= hold+1.
  - Saturates at LONG_MAX.
  - long_flag pulses in the cycle hold transitions LONG_MAX-1 -> LONG_MAX.
  - One long_flag per press. Release before saturation gives no long_flag; hold resets to 0.
- pending[i]:
  - Set by press_flag[i] or long_flag[i]; release events do not set it.
  - Cleared by irq_ack[i].
  - Set and ack in the same cycle: set wins (bit stays 1).
  - Ack of a 0 bit has no effect.
- irq <= |(pending & irq_en), registered one cycle after pending. Disabled channels still latch pending.
- Channels are fully independent; simultaneous events on several channels are all captured.

Test Plan:
Bench uses CNT_MAX=3, LONG_MAX=20, KEY_NUM=4, ACTIVE_LOW=1.
1. Reset, then key_in=4'hF for 20 cycles -> key_state=0, all flags 0, pending=0, irq=0.
2. key_in[0] driven low and held -> key_state[0]=1 and press_flag[0]=1 for exactly 1 cycle, 6 edges after the first low sample; pending[0]=1 next cycle; with irq_en=4'h1, irq=1 one cycle after that.
3. key_in[1] toggled low 3 cycles / high 1 cycle, repeated 10 times, then held high -> no press_flag[1], key_state[1] stays 0.
4. key_in[2] held low 40 cycles -> press_flag[2] once; long_flag[2] once, 20 cycles after press_flag; release then gives release_flag[2] once 6 edges after release, and no further long_flag.
5. pending[0]=1 with irq_ack[0] pulsed in the same cycle as a new press_flag[0] -> pending[0] stays 1. irq_ack[0] alone later -> pending[0]=0 and irq drops 1 cycle after.
6. sys_rst asserted while key_in[3] has been low 2 cycles, then released with key_in[3] still low -> no flags during reset; press_flag[3] occurs 6 edges after the first post-reset edge.
